// File: rtl/lpc_seq_pkg.sv
// Shared state encoding and datapath widths for the LPC frame sequencer.
package lpc_seq_pkg;
  localparam int SAMPLE_W = 16;
  localparam int ADDR_W   = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4,
    ERR   = 3'd5
  } seq_state_t;
endpackage

// File: rtl/lpc_residue_reader.sv
// Streams one frame out of the synchronous residue buffer (1-cycle read latency)
// through a single output register with valid/ready flow control.
module lpc_residue_reader
  import lpc_seq_pkg::*;
#(
  parameter int FRAME_LEN = 160
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       drain_en,
  output logic [ADDR_W-1:0]          residue_raddr,
  input  logic signed [SAMPLE_W-1:0] residue_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_data,
  output logic                       out_last,
  output logic                       frame_done
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  logic [ADDR_W-1:0]          ridx;
  logic                       pend_p0;
  logic                       fin;
  logic                       vld_p1;
  logic                       last_p1;
  logic signed [SAMPLE_W-1:0] data_p1;
  logic                       cap;
  logic                       at_last;

  // pend_p0 means residue_dout currently holds residue[ridx]; if it cannot be
  // captured, ridx is re-presented so the same word returns next cycle.
  assign at_last       = (ridx == LAST_IDX);
  assign cap           = pend_p0 & (~vld_p1 | out_ready);
  assign residue_raddr = (cap & ~at_last) ? ridx + ADDR_W'(1) : ridx;

  // Stage p0: address issue / read-return tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ridx    <= '0;
      pend_p0 <= 1'b0;
      fin     <= 1'b0;
    end else if (!drain_en) begin
      ridx    <= '0;
      pend_p0 <= 1'b0;
      fin     <= 1'b0;
    end else begin
      if (cap) begin
        ridx <= at_last ? '0 : ridx + ADDR_W'(1);
        fin  <= fin | at_last;
      end
      pend_p0 <= ~fin & ~(cap & at_last);
    end
  end

  // Stage p1: output register, held while stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
    end else if (cap) begin
      vld_p1  <= 1'b1;
      last_p1 <= at_last;
      data_p1 <= residue_dout;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign out_valid  = vld_p1;
  assign out_data   = data_p1;
  assign out_last   = last_p1;
  assign frame_done = vld_p1 & out_ready & last_p1;
endmodule

// File: rtl/lpc_frame_sequencer.sv
// Frame scheduler around the LPC encoder: load x buffer, start, wait, drain residue.
// Optional enc_done watchdog and err port enabled by defining LPC_SEQ_TIMEOUT_EN.
module lpc_frame_sequencer
  import lpc_seq_pkg::*;
#(
  parameter int FRAME_LEN    = 160,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [SAMPLE_W-1:0] in_data,
  output logic                       x_wen,
  output logic [ADDR_W-1:0]          x_waddr,
  output logic signed [SAMPLE_W-1:0] x_din,
  output logic                       enc_start,
  input  logic                       enc_done,
  output logic [ADDR_W-1:0]          residue_raddr,
  input  logic signed [SAMPLE_W-1:0] residue_dout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [SAMPLE_W-1:0] out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic [15:0]                frame_cnt
`ifdef LPC_SEQ_TIMEOUT_EN
  ,
  output logic                       err
`endif
);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FRAME_LEN - 1);
  localparam logic [15:0]       START_LAST = 16'(START_CYCLES - 1);

  if (FRAME_LEN < 1 || FRAME_LEN > 256 || START_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("lpc_frame_sequencer: parameter out of range");
  end

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       scnt;
  logic              settled;
  logic              hs;
  logic              drain_en;
  logic              frame_done;

`ifdef LPC_SEQ_TIMEOUT_EN
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wdog;
`endif

  assign in_ready  = (state == LOAD);
  assign hs        = in_valid & in_ready;
  assign x_wen     = hs;
  assign x_waddr   = idx;
  assign x_din     = hs ? in_data : '0;
  assign enc_start = (state == START);
  assign busy      = (state != IDLE);
  assign drain_en  = (state == DRAIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // settled blocks a done level left over from the previous frame during the
  // first WAIT cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable) state_nxt = LOAD;
      LOAD:  if (hs && idx == LAST_IDX) state_nxt = START;
      START: if (scnt == START_LAST) state_nxt = WAIT;
      WAIT: begin
        if (settled && enc_done) state_nxt = DRAIN;
`ifdef LPC_SEQ_TIMEOUT_EN
        else if (wdog == WDOG_LAST) state_nxt = ERR;
`endif
      end
      DRAIN: if (frame_done) state_nxt = enable ? LOAD : IDLE;
      ERR:   if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      scnt      <= '0;
      settled   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (hs) idx <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
      scnt    <= (state == START) ? scnt + 16'd1 : '0;
      settled <= (state == WAIT);
      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef LPC_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog <= '0;
    else       wdog <= (state == WAIT) ? wdog + 16'd1 : '0;
  end

  assign err = (state == ERR);
`endif

  lpc_residue_reader #(
    .FRAME_LEN(FRAME_LEN)
  ) u_reader (
    .clk          (clk),
    .reset        (reset),
    .drain_en     (drain_en),
    .residue_raddr(residue_raddr),
    .residue_dout (residue_dout),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_done   (frame_done)
  );
endmodule

// File: doc/lpc_frame_sequencer.md
Name: lpc_frame_sequencer

Overview:
Frame-level scheduler wrapped around the LPC encode datapath. It accepts a sample stream and writes one FRAME_LEN-sample frame into the encoder's x buffer, then pulses the encoder start. It waits for encode completion and drains the residue buffer as an output stream with backpressure. It repeats per frame, so the encoder is driven from streaming interfaces instead of direct buffer access.

Parameters:
FRAME_LEN, 160, samples per frame; must be at most 256.
START_CYCLES, 2, cycles the start pulse is held high (start also resets autocorrelation); minimum 1.
TIMEOUT, 65535, enc_done watchdog limit in cycles; used only with LPC_SEQ_TIMEOUT_EN.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; when 1, the sequencer may start a new frame from IDLE
in_valid  in  1  input sample valid
in_ready  out  1  sequencer can accept an input sample
in_data  in  16  input sample, two's complement
x_wen  out  1  x buffer write enable
x_waddr  out  8  x buffer write address
x_din  out  16  x buffer write data
enc_start  out  1  encoder start/reset pulse
enc_done  in  1  encoder finished; level, sampled only in WAIT
residue_raddr  out  8  residue buffer read address
residue_dout  in  16  residue read data, valid 1 cycle after raddr
out_valid  out  1  residue sample valid
out_ready  in  1  downstream accepts the sample
out_data  out  16  residue sample
out_last  out  1  high with the final sample of a frame
busy  out  1  high in any state other than IDLE
frame_cnt  out  16  completed frames, wraps at 65535 to 0

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- IDLE: if enable=1, go to LOAD next cycle. If enable=0, stay in IDLE.
- LOAD: in_ready=1. On each handshake (in_valid & in_ready), in the same cycle:
  - x_wen=1, x_waddr=idx, x_din=in_data (combinational pass-through).
  - idx then increments.
  - When the handshake occurs at idx=FRAME_LEN-1: idx clears and the state goes to START.
- START: in_ready=0, enc_start=1 for exactly START_CYCLES cycles, then go to WAIT.
- WAIT: enc_start=0. enc_done is ignored during the first cycle of WAIT so a stale done from the previous frame is not taken. After that, enc_done=1 moves the state to DRAIN.
- DRAIN read pipeline:
  - residue_raddr=ridx is issued. Data is captured into an output register 1 cycle later, which sets out_valid.
  - The read address advances only when the output register is empty, or is being emptied this cycle (out_valid & out_ready).
  - Throughput is 1 sample/cycle when out_ready is held at 1. out_data is held stable while out_valid=1 and out_ready=0.
  - Sample k carries residue[k], for k = 0 to FRAME_LEN-1.
  - out_last=1 only with k=FRAME_LEN-1.
  - When the last handshake occurs, frame_cnt increments. The state then goes to LOAD if enable=1, or to IDLE if enable=0.
- enable falling mid-frame does not abort the frame; it only prevents the next frame from starting.
- reset asserted mid-operation returns everything to the reset values immediately (asynchronous reset). The partially written x buffer is simply overwritten on the next frame.
- x_wen and residue reads never overlap; the encoder is never started during LOAD or DRAIN.
- Address widths: idx and ridx are 8 bits and compare against FRAME_LEN-1; no wrap occurs within a frame.

Optional Feature:
LPC_SEQ_TIMEOUT_EN:
- When defined, a 16-bit watchdog counts cycles in WAIT.
- If it reaches TIMEOUT before enc_done, the state goes to ERR. In ERR, the added output port err=1, and no streaming occurs.
- ERR exits only on reset, or when enable=0 for 1 cycle (which returns to IDLE and clears err).
- When not defined, the err port and the counter are absent and WAIT waits indefinitely.

Decomposition:
- Package lpc_seq_pkg holds:
  - the state encoding constants IDLE, LOAD, START, WAIT, DRAIN, ERR (3 bits);
  - the sample width SAMPLE_W=16;
  - the address width ADDR_W=8.
- One sub-module is natural: lpc_residue_reader. It contains the 1-cycle-latency read plus output register and valid/ready logic, and is driven by a drain-enable from the FSM. Everything else stays flat.

Test Plan:
- Basic frame: reset, enable=1, stream 160 samples 0..159 with in_valid held high. Expect x_wen on 160 consecutive cycles with addresses 0..159, enc_start high for 2 cycles, and no out_valid before enc_done. Model enc_done at 50 cycles. Expect 160 outputs equal to the model's residue with out_ready=1, out_last on output 159, frame_cnt=1.
- Backpressure: toggle out_ready randomly at 50%. Expect no drops or duplicates, out_data stable while stalled, and exactly 160 handshakes.
- Input gaps: in_valid toggled randomly. Expect x_waddr to increment only on handshakes and x_din to equal the accepted in_data.
- Stale done: hold enc_done=1 continuously from the previous frame. Expect WAIT to last at least 2 cycles and exactly one drain per frame.
- Mid-frame reset: assert reset at LOAD sample 80. Expect all outputs 0 immediately, the next frame to start writing from address 0, and frame_cnt=0.
- Timeout (with LPC_SEQ_TIMEOUT_EN, TIMEOUT=100): never assert enc_done. Expect err=1 at WAIT cycle 100 and no out_valid; enable=0 for 1 cycle clears err and returns to IDLE.
